// File: rtl/kpn_mult_pkg.sv
// Shared constants, state encoding and helpers for the
// KPN multiplier scheduler.
package kpn_mult_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_MULT_LATENCY = 1;
  localparam int CNT_W            = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_WAIT    = ST_WAIT,
    S_RESPOND = ST_RESPOND
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multiplier_module.sv
// Pipelined unsigned multiplier; output_1 is registered
// LATENCY edges after entry_1/entry_2 are presented.
module multiplier_module
  import kpn_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = DEF_MULT_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   entry_1,
  input  logic [DATA_WIDTH-1:0]   entry_2,
  output logic [2*DATA_WIDTH-1:0] output_1
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] r_pipe [LATENCY];
  logic [PW-1:0] w_prod;

  assign w_prod = PW'(entry_1) * PW'(entry_2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign output_1 = r_pipe[LATENCY-1];

endmodule

// File: rtl/rr_arbiter_module.sv
// Combinational round-robin arbiter; search starts one
// above last_grant and wraps. Pointer lives in the caller.
module rr_arbiter_module
  import kpn_mult_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]        request,
  input  logic [clog2(NUM_REQ)-1:0] last_grant,
  input  logic                      enable,
  output logic [NUM_REQ-1:0]        grant,
  output logic [clog2(NUM_REQ)-1:0] grant_index,
  output logic                      grant_valid
);

  localparam int IDX_W = clog2(NUM_REQ);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    w_j         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (enable && !grant_valid && request[w_j]) begin
        grant[w_j]  = 1'b1;
        grant_index = w_j;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier_scheduler_module.sv
// Round-robin scheduler sharing one multiplier among
// NUM_REQ producers; one operation in flight at a time.
module multiplier_scheduler_module
  import kpn_mult_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_entry_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_entry_2,
  output logic [DATA_WIDTH-1:0]           mult_entry_1,
  output logic [DATA_WIDTH-1:0]           mult_entry_2,
  input  logic [2*DATA_WIDTH-1:0]         mult_output_1,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [clog2(NUM_REQ)-1:0]       resp_id,
  output logic [2*DATA_WIDTH-1:0]         resp_data,
  output logic                            busy
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int PW    = 2 * DATA_WIDTH;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]      r_last_grant;
  logic [IDX_W-1:0]      r_resp_id;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_entry_1;
  logic [DATA_WIDTH-1:0] r_entry_2;
  logic [PW-1:0]         r_resp_data;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_gidx;
  logic                  w_accept;
  logic                  w_arb_en;
  logic                  w_wait_end;
  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;

  // Arbitration is held off during reset so no accept
  // pulse is shown for a request that will be discarded.
  assign w_arb_en = (r_state == S_IDLE) && !reset;

  rr_arbiter_module #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .request     (req_valid),
    .last_grant  (r_last_grant),
    .enable      (w_arb_en),
    .grant       (w_grant),
    .grant_index (w_gidx),
    .grant_valid (w_accept)
  );

  assign w_wait_end = (r_state == S_WAIT)
                   && (r_wait_cnt == '0);

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDX_W'(i)) begin
        w_op1 = req_entry_1[i*DATA_WIDTH +: DATA_WIDTH];
        w_op2 = req_entry_2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept)   w_next = S_WAIT;
      S_WAIT:    if (w_wait_end) w_next = S_RESPOND;
      S_RESPOND: if (resp_ready) w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_resp_id    <= '0;
      r_wait_cnt   <= '0;
      r_entry_1    <= '0;
      r_entry_2    <= '0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_entry_1    <= w_op1;
        r_entry_2    <= w_op2;
        r_resp_id    <= w_gidx;
        r_last_grant <= w_gidx;
        r_wait_cnt   <= CNT_W'(MULT_LATENCY);
      end else if (r_state == S_WAIT
                   && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_wait_end) r_resp_data <= mult_output_1;
    end
  end

  assign req_ready    = w_grant;
  assign mult_entry_1 = r_entry_1;
  assign mult_entry_2 = r_entry_2;
  assign resp_valid   = (r_state == S_RESPOND);
  assign resp_id      = r_resp_id;
  assign resp_data    = r_resp_data;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_multiplier_scheduler_module.sv
// Bench: scheduler plus multiplier, checked against a
// transaction-level round-robin/product reference model.
module tb_multiplier_scheduler_module;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int L  = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_entry_1;
  logic [NR*DW-1:0] req_entry_2;
  logic [DW-1:0]    mult_entry_1;
  logic [DW-1:0]    mult_entry_2;
  logic [2*DW-1:0]  mult_output_1;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic [2*DW-1:0]  resp_data;
  logic             busy;

  multiplier_scheduler_module #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MULT_LATENCY (L)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_entry_1   (req_entry_1),
    .req_entry_2   (req_entry_2),
    .mult_entry_1  (mult_entry_1),
    .mult_entry_2  (mult_entry_2),
    .mult_output_1 (mult_output_1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .busy          (busy)
  );

  multiplier_module #(
    .DATA_WIDTH (DW),
    .LATENCY    (L)
  ) u_mult (
    .clk      (clk),
    .reset    (reset),
    .entry_1  (mult_entry_1),
    .entry_2  (mult_entry_2),
    .output_1 (mult_output_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] op_a [NR];
  logic [DW-1:0] op_b [NR];
  int m_last;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_entry_1[i*DW +: DW] = op_a[i];
      req_entry_2[i*DW +: DW] = op_b[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = DW'($urandom);
      op_b[i] = DW'($urandom);
    end
    drive_ops();
  endtask

  // Reference arbiter: first valid requester after the
  // previous winner, wrapping around.
  function automatic int pick(input logic [NR-1:0] m,
                              input int last);
    for (int k = 1; k <= NR; k++) begin
      if (m[(last + k) % NR]) return (last + k) % NR;
    end
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_mult_e1"}, 32'(mult_entry_1), 32'd0);
    chk({tag, "_mult_e2"}, 32'(mult_entry_2), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_last = NR - 1;
  endtask

  // Runs n operations with vmask valid; operation stall_op
  // keeps resp_ready low for stall cycles of RESPOND.
  task automatic serve(input logic [NR-1:0] vmask,
                       input int n,
                       input int stall_op,
                       input int stall);
    int g, k, t_acc, t_prev, prev_extra;
    logic [31:0] ep;
    logic [DW-1:0] ea, eb;
    t_prev     = -1;
    prev_extra = 0;
    req_valid  = vmask;
    drive_ops();
    for (int op = 0; op < n; op++) begin
      resp_ready = (op == stall_op) ? 1'b0 : 1'b1;
      @(negedge clk);
      k = 0;
      while (req_ready == '0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      g = pick(vmask, m_last);
      chk("grant", 32'(req_ready), 32'(1) << g);
      if (req_ready == '0) break;
      chk("busy_idle", 32'(busy), 32'd0);
      if (t_prev >= 0)
        chk("spacing", 32'(cyc - t_prev),
            32'(L + 3 + prev_extra));
      m_last = g;
      ea     = op_a[g];
      eb     = op_b[g];
      ep     = 32'(ea) * 32'(eb);
      t_acc  = cyc;
      @(posedge clk);
      #1;
      op_a[g] = DW'($urandom);
      op_b[g] = DW'($urandom);
      drive_ops();
      if (op == n - 1) req_valid = '0;
      @(negedge clk);
      k = 0;
      while (!resp_valid && k < 20) begin
        chk("wait_ready", 32'(req_ready), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        k++;
      end
      chk("latency", 32'(cyc - t_acc), 32'(L + 2));
      if (!resp_valid) break;
      chk("resp_id", 32'(resp_id), 32'(g));
      chk("resp_data", resp_data, ep);
      chk("mult_e1", 32'(mult_entry_1), 32'(ea));
      chk("mult_e2", 32'(mult_entry_2), 32'(eb));
      if (op == stall_op) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_valid", 32'(resp_valid), 32'd1);
          chk("stall_data", resp_data, ep);
          chk("stall_id", 32'(resp_id), 32'(g));
          chk("stall_ready", 32'(req_ready), 32'd0);
          chk("stall_busy", 32'(busy), 32'd1);
          @(negedge clk);
        end
        resp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      t_prev     = t_acc;
      prev_extra = (op == stall_op) ? stall : 0;
    end
    req_valid = '0;
  endtask

  initial begin
    logic [NR-1:0] m;
    int k;
    reset       = 1'b1;
    req_valid   = '0;
    resp_ready  = 1'b1;
    req_entry_1 = '0;
    req_entry_2 = '0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // single operation from requester 0
    do_reset();
    op_a[0] = 16'd20;
    op_b[0] = 16'd20;
    serve(4'b0001, 1, -1, 0);
    @(negedge clk);
    chk("idle_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // all four valid, fresh pointer
    do_reset();
    op_a[0] = 16'd5;     op_b[0] = 16'd5;
    op_a[1] = 16'd10;    op_b[1] = 16'd9;
    op_a[2] = 16'd3;     op_b[2] = 16'd7;
    op_a[3] = 16'hFFFF;  op_b[3] = 16'hFFFF;
    serve(4'b1111, 4, -1, 0);

    // requester 2 stalled for 10 cycles
    serve(4'b1111, 4, 2, 10);

    // only 1 and 3 valid: wrap and skip
    serve(4'b1010, 3, -1, 0);

    // single requester alone
    serve(4'b0100, 3, -1, 0);

    // randomized masks and operands
    repeat (8) begin
      rand_ops();
      m = NR'($urandom_range(1, 15));
      serve(m, $urandom_range(1, 5), -1, 0);
    end
    rand_ops();
    serve(4'b1111, 4, $urandom_range(0, 3),
          $urandom_range(1, 6));

    // reset during WAIT discards the operation
    op_a[1] = 16'd10;
    op_b[1] = 16'd9;
    drive_ops();
    req_valid = 4'b0010;
    @(negedge clk);
    k = 0;
    while (req_ready == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rw_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rw_busy_wait", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rw");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_last = NR - 1;
    repeat (4) begin
      @(negedge clk);
      chk("rw_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rand_ops();
    serve(4'b1111, 1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiplier_scheduler_module.md
# multiplier_scheduler_module

Shares one `multiplier_module` among `NUM_REQ` KPN producer processes. Each producer presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one producer at a time and drives the operands into the multiplier. The scheduler waits out the multiplier latency, then returns the 32-bit product tagged with the requester id on a single valid/ready result channel. It sits between the KPN process FIFOs and the shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 16: operand width. The product is 2*DATA_WIDTH.
- `MULT_LATENCY`, default 1: clock edges from `multiplier_module` input to registered `output_1`. Range 1..7.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: bit i = requester i has an operand pair.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `req_entry_1` in NUM_REQ*DATA_WIDTH: packed first operands, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_entry_2` in NUM_REQ*DATA_WIDTH: packed second operands, same slicing.
- `mult_entry_1` out DATA_WIDTH: to multiplier `entry_1`, registered.
- `mult_entry_2` out DATA_WIDTH: to multiplier `entry_2`, registered.
- `mult_output_1` in 2*DATA_WIDTH: from multiplier `output_1`.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts result.
- `resp_id` out clog2(NUM_REQ): index of the requester that owns the result.
- `resp_data` out 2*DATA_WIDTH: unsigned product.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESPOND. Only one operation is in flight.
- IDLE:
  - If any `req_valid` bit is set, grant g = first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `req_ready[g]`=1 combinationally in this cycle only. That cycle is the accept handshake.
  - At the edge: latch the operands of g into `mult_entry_1/2`, `resp_id`<=g, `last_grant`<=g, `wait_cnt`<=MULT_LATENCY, go to WAIT.
  - If no `req_valid` bit is set, stay in IDLE; `req_ready`=0.
- WAIT:
  - `wait_cnt` decrements each cycle.
  - In the cycle with `wait_cnt`==0, `mult_output_1` is valid for the held operands. At that edge, `resp_data`<=`mult_output_1` and the FSM goes to RESPOND.
- RESPOND:
  - `resp_valid`=1. `resp_data` and `resp_id` are stable.
  - On `resp_valid && resp_ready`, go to IDLE. The next grant can occur in the following cycle.
- `mult_entry_1/2` hold their last operands between operations and are never cleared except by reset.
- `req_ready` is never asserted outside IDLE, and never for a requester whose `req_valid`=0.
- Producers must hold `req_valid` and operands until accepted. The scheduler never drops an accepted request.
- Arithmetic is unsigned with a full 2*DATA_WIDTH product. There is no truncation or saturation.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0.
  - `mult_entry_1/2`=0, `busy`=0.
  - `last_grant`=NUM_REQ-1, so requester 0 wins the first arbitration.
  - `wait_cnt`=0.
- Latency: with accept in cycle A, operands are on the multiplier in A+1 and `resp_valid` rises in A+2+MULT_LATENCY. With the default latency that is 3 cycles.
- Minimum spacing between accepts: MULT_LATENCY+3 cycles when `resp_ready` is held high.
- A stalled `resp_ready` holds RESPOND indefinitely. No new request is accepted meanwhile.
- All requesters valid continuously: grants rotate 0,1,2,3,0,… Each requester gets exactly one grant per NUM_REQ operations.
- A single requester valid alone gets a grant on every IDLE visit, regardless of pointer position.
- Reset asserted in any state, including WAIT or RESPOND: the in-flight operation is discarded with no response. All outputs take reset values at the next edge.
- `req_valid` dropping in a non-accept cycle has no effect. Inputs are sampled only in IDLE.

## Structure
- Package `kpn_mult_pkg`:
  - State encoding localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESPOND=2'd2.
  - Default width constants.
  - A clog2 function.
- Sub-module `rr_arbiter_module`:
  - Parameters NUM_REQ; inputs `request` vector, `last_grant`, `enable`.
  - Outputs one-hot `grant`, `grant_index`, `grant_valid`.
  - Purely combinational; the pointer register lives in the scheduler.
- The top-level bench instantiates the scheduler plus the real `multiplier_module` with MULT_LATENCY=1.

## Test plan
- Reset, then requester 0 sends 20,20 with `resp_ready`=1. Expect: `req_ready[0]` in cycle A, `resp_valid` in A+3, `resp_id`=0, `resp_data`=400, then IDLE.
- All four requesters valid with pairs (5,5), (10,9), (3,7), (65535,65535). Expect grants in order 0,1,2,3 and results 25, 90, 21, 32'hFFFE0001 with matching ids, spaced 4 cycles apart.
- Requester 2 result with `resp_ready` held 0 for 10 cycles. Expect `resp_valid`=1, `resp_data` stable, `req_ready`=0 throughout, and `busy`=1; on release the result completes and the next grant follows.
- After grant to 3, only requesters 1 and 3 are valid. Expect grant to 1, then 3, then 1: wrap-around and skipping of idle requesters.
- Assert `reset` during WAIT of a 10×9 operation. Expect no `resp_valid`, all outputs 0 next cycle, and requester 0 granted first after release.
